// File: rtl/dmem_access_ctrl_if.sv
// Bundles the MEM-stage, debug-unit and data-memory buses of dmem_access_ctrl.
// slave is the controller's view; master is the environment's view.
interface dmem_access_ctrl_if;
    logic        i_mem_valid;
    logic        i_mem_we;
    logic [1:0]  i_mem_size;
    logic        i_mem_unsigned;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_wdata;
    logic [31:0] o_mem_rdata;
    logic        o_mem_stall;
    logic        o_mem_err;

    logic        i_du_req;
    logic [31:0] i_du_addr;
    logic [31:0] o_du_rdata;
    logic        o_du_ack;

    logic [31:0] o_dm_addr;
    logic [31:0] o_dm_wdata;
    logic        o_dm_we;
    logic [31:0] i_dm_rdata;

    modport slave (
        input  i_mem_valid, i_mem_we, i_mem_size, i_mem_unsigned, i_mem_addr, i_mem_wdata,
        output o_mem_rdata, o_mem_stall, o_mem_err,
        input  i_du_req, i_du_addr,
        output o_du_rdata, o_du_ack,
        output o_dm_addr, o_dm_wdata, o_dm_we,
        input  i_dm_rdata
    );

    modport master (
        output i_mem_valid, i_mem_we, i_mem_size, i_mem_unsigned, i_mem_addr, i_mem_wdata,
        input  o_mem_rdata, o_mem_stall, o_mem_err,
        output i_du_req, i_du_addr,
        input  o_du_rdata, o_du_ack,
        input  o_dm_addr, o_dm_wdata, o_dm_we,
        output i_dm_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory sequencer: load extension, sub-word store read-modify-write, error detection
// and bounded-wait DU arbitration. Define DMEM_CTRL_STATS_EN to build the statistics counters.
//
// Handshake: MEM stage presents an access while i_mem_valid=1 and holds it while o_mem_stall=1;
// the access completes on the first edge with o_mem_stall=0. DU holds i_du_req until the
// single-cycle o_du_ack, during which o_du_rdata is valid.
module dmem_access_ctrl #(
    parameter int DMEM_BYTES  = 256,
    parameter int DU_MAX_WAIT = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    dmem_access_ctrl_if.slave   bus,
    output logic [1:0]          dbg_state,
    output logic [31:0]         o_stat_loads,
    output logic [31:0]         o_stat_stores,
    output logic [31:0]         o_stat_rmw,
    output logic [31:0]         o_stat_stall
);
    typedef enum logic [1:0] {IDLE = 2'd0, MERGE = 2'd1, WRITE = 2'd2, DU = 2'd3} state_t;

    localparam int CW = $clog2(DU_MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(DU_MAX_WAIT);

    state_t        state, state_next;
    logic [CW-1:0] wait_cnt;
    logic          err_q;
    logic [31:0]   du_rdata_q;
    logic [31:0]   merge_q;
    logic [31:0]   cap_addr;
    logic          cap_half;
    logic [15:0]   cap_data;

    logic [2:0]    access_bytes;
    logic [32:0]   end_addr;
    logic          mem_err_cond;
    logic          du_grant;
    logic [31:0]   merged;
    logic          err_set, capture, du_capture;

    function automatic logic [31:0] load_ext(logic [31:0] word, logic [1:0] size,
                                             logic [1:0] lane, logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {lane, 3'b000});
        h = 16'(word >> {lane[1], 4'b0000});
        case (size)
            2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_word(logic [31:0] old, logic half,
                                               logic [1:0] lane, logic [15:0] data);
        logic [4:0]  sh;
        logic [31:0] mask, ins;
        if (half) begin
            sh   = {lane[1], 4'b0000};
            mask = 32'h0000_FFFF << sh;
            ins  = {16'h0, data} << sh;
        end else begin
            sh   = {lane, 3'b000};
            mask = 32'h0000_00FF << sh;
            ins  = {24'h0, data[7:0]} << sh;
        end
        return (old & ~mask) | ins;
    endfunction

    always_comb begin
        case (bus.i_mem_size)
            2'b00:   access_bytes = 3'd1;
            2'b01:   access_bytes = 3'd2;
            default: access_bytes = 3'd4;
        endcase
    end

    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    assign end_addr     = {1'b0, bus.i_mem_addr} + {30'b0, access_bytes};
    assign mem_err_cond = (bus.i_mem_size == 2'b11)
                        || (bus.i_mem_size == 2'b01 && bus.i_mem_addr[0])
                        || (bus.i_mem_size == 2'b10 && bus.i_mem_addr[1:0] != 2'b00)
                        || (end_addr > 33'(DMEM_BYTES));
    assign du_grant     = (state == IDLE) && bus.i_du_req
                        && (!bus.i_mem_valid || wait_cnt == WAIT_MAX);
    assign merged       = merge_word(bus.i_dm_rdata, cap_half, cap_addr[1:0], cap_data);

    always_comb begin
        state_next      = state;
        bus.o_dm_addr   = {bus.i_mem_addr[31:2], 2'b00};
        bus.o_dm_wdata  = bus.i_mem_wdata;
        bus.o_dm_we     = 1'b0;
        bus.o_mem_stall = 1'b0;
        bus.o_mem_rdata = 32'h0;
        bus.o_du_ack    = 1'b0;
        err_set         = 1'b0;
        capture         = 1'b0;
        du_capture      = 1'b0;
        case (state)
            IDLE: begin
                if (du_grant) begin
                    bus.o_dm_addr   = bus.i_du_addr & 32'hFFFF_FFFC;
                    bus.o_mem_stall = bus.i_mem_valid;
                    du_capture      = 1'b1;
                    state_next      = DU;
                end else if (bus.i_mem_valid) begin
                    if (mem_err_cond) begin
                        err_set = 1'b1;
                    end else if (!bus.i_mem_we) begin
                        bus.o_mem_rdata = load_ext(bus.i_dm_rdata, bus.i_mem_size,
                                                   bus.i_mem_addr[1:0], bus.i_mem_unsigned);
                    end else if (bus.i_mem_size == 2'b10) begin
                        bus.o_dm_we = 1'b1;
                    end else begin
                        bus.o_mem_stall = 1'b1;
                        capture         = 1'b1;
                        state_next      = MERGE;
                    end
                end
            end
            MERGE: begin
                bus.o_dm_addr   = {cap_addr[31:2], 2'b00};
                bus.o_mem_stall = 1'b1;
                state_next      = WRITE;
            end
            WRITE: begin
                bus.o_dm_addr  = {cap_addr[31:2], 2'b00};
                bus.o_dm_wdata = merge_q;
                bus.o_dm_we    = 1'b1;
                state_next     = IDLE;
            end
            DU: begin
                bus.o_du_ack    = 1'b1;
                bus.o_mem_stall = bus.i_mem_valid;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (i_reset) begin
            bus.o_dm_we     = 1'b0;
            bus.o_mem_stall = 1'b0;
            bus.o_du_ack    = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            err_q      <= 1'b0;
            du_rdata_q <= 32'h0;
            merge_q    <= 32'h0;
            cap_addr   <= 32'h0;
            cap_half   <= 1'b0;
            cap_data   <= 16'h0;
        end else begin
            state <= state_next;
            if (err_set)
                err_q <= 1'b1;
            if (capture) begin
                cap_addr <= bus.i_mem_addr;
                cap_half <= bus.i_mem_size[0];
                cap_data <= bus.i_mem_wdata[15:0];
            end
            if (state == MERGE)
                merge_q <= merged;
            if (du_capture)
                du_rdata_q <= bus.i_dm_rdata;
            if (state == DU)
                wait_cnt <= '0;
            else if (bus.i_du_req && !du_grant && wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign bus.o_mem_err  = err_q;
    assign bus.o_du_rdata = du_rdata_q;
    assign dbg_state      = state;

`ifdef DMEM_CTRL_STATS_EN
    logic        idle_mem;
    logic [31:0] n_loads, n_stores, n_rmw, n_stall;

    assign idle_mem = (state == IDLE) && !du_grant && bus.i_mem_valid && !mem_err_cond;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            n_loads  <= 32'h0;
            n_stores <= 32'h0;
            n_rmw    <= 32'h0;
            n_stall  <= 32'h0;
        end else begin
            if (idle_mem && !bus.i_mem_we)
                n_loads <= n_loads + 32'd1;
            if ((idle_mem && bus.i_mem_we && bus.i_mem_size == 2'b10) || state == WRITE)
                n_stores <= n_stores + 32'd1;
            if (state == WRITE)
                n_rmw <= n_rmw + 32'd1;
            if (bus.o_mem_stall)
                n_stall <= n_stall + 32'd1;
        end
    end

    assign o_stat_loads  = n_loads;
    assign o_stat_stores = n_stores;
    assign o_stat_rmw    = n_rmw;
    assign o_stat_stall  = n_stall;
`else
    assign o_stat_loads  = 32'h0;
    assign o_stat_stores = 32'h0;
    assign o_stat_rmw    = 32'h0;
    assign o_stat_stall  = 32'h0;
`endif
endmodule
